// File: rtl/ling_adder_pipe_if.sv
// Operand/result stream bundle for the pipelined Ling adder.
interface ling_adder_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    // Operand issuer / result consumer side.
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/ling_adder_pipe.sv
// Three-stage pipelined Ling adder/subtractor with valid/ready back-pressure.
// S1: bit generate/propagate plus in-group Ling pseudo-carries (c0 folded into group 0).
// S2: group-level prefix over (R, Q) pairs, then full per-bit pseudo-carry H.
// S3: carries c_i = p_i & H_i, sum, carry-out and signed overflow.
module ling_adder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic clk,
    input  logic rst_n,
    ling_adder_pipe_if.slave bus
);
    localparam int unsigned NG = WIDTH / GROUP;
    localparam int unsigned LV = (NG > 1) ? $clog2(NG) : 1;

    logic             load1, load2, load3;
    logic             v1, v2, v3;

    logic [WIDTH-1:0] bx, g0, p0, x0, hl0, ql0;
    logic             c0;

    logic [WIDTH-1:0] p1, x1, hl1, ql1;
    logic             c01;

    logic [NG-1:0]    rg, qg, rg_n, qg_n;
    logic [WIDTH-1:0] h2_n;
    logic             gin;

    logic [WIDTH-1:0] p2, x2, h2;
    logic             c02;

    logic [WIDTH-1:0] cy3, sum_n;
    logic             cout_n, ovf_n;

    logic [WIDTH-1:0] sum3;
    logic             cout3, ovf3;

    // Stage advance: a stage loads when upstream is valid and it is empty or draining.
    assign load3        = v2 & (~v3 | bus.out_ready);
    assign load2        = v1 & (~v2 | load3);
    assign bus.in_ready = ~v1 | load2;
    assign load1        = bus.in_valid & bus.in_ready;

    assign bus.out_valid = v3;
    assign bus.out_sum   = sum3;
    assign bus.out_cout  = cout3;
    assign bus.out_ovf   = ovf3;

    // Bit-level g/p/x and in-group pseudo-carries H (local) and shifted propagate Q.
    always_comb begin
        c0  = bus.in_sub | bus.in_cin;
        bx  = bus.in_b ^ {WIDTH{bus.in_sub}};
        g0  = bus.in_a & bx;
        p0  = bus.in_a | bx;
        x0  = bus.in_a ^ bx;
        hl0 = '0;
        ql0 = '0;
        hl0[0] = g0[0] | c0;
        ql0[0] = 1'b1;
        for (int i = 1; i < int'(WIDTH); i++) begin
            if ((i % int'(GROUP)) == 0) begin
                hl0[i] = g0[i];
                ql0[i] = p0[i-1];
            end else begin
                hl0[i] = g0[i] | (p0[i-1] & hl0[i-1]);
                ql0[i] = ql0[i-1] & p0[i-1];
            end
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            p1  <= '0;
            x1  <= '0;
            hl1 <= '0;
            ql1 <= '0;
            c01 <= 1'b0;
        end else begin
            if (load1) begin
                v1 <= 1'b1;
            end else if (load2) begin
                v1 <= 1'b0;
            end
            if (load1) begin
                p1  <= p0;
                x1  <= x0;
                hl1 <= hl0;
                ql1 <= ql0;
                c01 <= c0;
            end
        end
    end

    // Group prefix R = R | Q*R(prior) over log2(NG) levels, then per-bit H.
    always_comb begin
        rg   = '0;
        qg   = '0;
        rg_n = '0;
        qg_n = '0;
        h2_n = '0;
        gin  = 1'b0;
        for (int j = 0; j < int'(NG); j++) begin
            rg[j] = hl1[j*int'(GROUP) + int'(GROUP) - 1];
            qg[j] = ql1[j*int'(GROUP) + int'(GROUP) - 1];
        end
        for (int lv = 0; lv < int'(LV); lv++) begin
            rg_n = rg;
            qg_n = qg;
            for (int j = (1 << lv); j < int'(NG); j++) begin
                rg_n[j] = rg[j] | (qg[j] & rg[j - (1 << lv)]);
                qg_n[j] = qg[j] & qg[j - (1 << lv)];
            end
            rg = rg_n;
            qg = qg_n;
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            gin     = (i < int'(GROUP)) ? 1'b0 : rg[i / int'(GROUP) - 1];
            h2_n[i] = hl1[i] | (ql1[i] & gin);
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            p2  <= '0;
            x2  <= '0;
            h2  <= '0;
            c02 <= 1'b0;
        end else begin
            if (load2) begin
                v2 <= 1'b1;
            end else if (load3) begin
                v2 <= 1'b0;
            end
            if (load2) begin
                p2  <= p1;
                x2  <= x1;
                h2  <= h2_n;
                c02 <= c01;
            end
        end
    end

    // Real carries from Ling pseudo-carries; sum, carry-out and overflow.
    always_comb begin
        cy3    = p2 & h2;
        sum_n  = x2 ^ {cy3[WIDTH-2:0], c02};
        cout_n = cy3[WIDTH-1];
        ovf_n  = cy3[WIDTH-1] ^ cy3[WIDTH-2];
    end

    // Stage 3 (output) register; payload held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3    <= 1'b0;
            sum3  <= '0;
            cout3 <= 1'b0;
            ovf3  <= 1'b0;
        end else begin
            if (load3) begin
                v3 <= 1'b1;
            end else if (bus.out_ready) begin
                v3 <= 1'b0;
            end
            if (load3) begin
                sum3  <= sum_n;
                cout3 <= cout_n;
                ovf3  <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_ling_adder_pipe.sv
// Bench for ling_adder_pipe: four widths (8/16/32/64) driven in lockstep,
// checked against an arithmetic model and a beat-level pipeline occupancy model.
module tb_ling_adder_pipe;
    typedef struct packed {
        logic [3:0][63:0] a;
        logic [3:0][63:0] b;
        logic             cin;
        logic             sub;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid, out_ready, cin_d, sub_d;
    logic [3:0][63:0] a_d, b_d;

    logic             ovalid [4];
    logic             iready [4];
    logic             ocout  [4];
    logic             oovf   [4];
    logic [63:0]      osum   [4];

    int               checks = 0;
    int               errors = 0;
    int               emitted = 0;
    bit               last_acc;
    beat_t            q [$];
    int               stg [$];

    ling_adder_pipe_if #(.WIDTH(8))  if8 ();
    ling_adder_pipe_if #(.WIDTH(16)) if16 ();
    ling_adder_pipe_if #(.WIDTH(32)) if32 ();
    ling_adder_pipe_if #(.WIDTH(64)) if64 ();

    ling_adder_pipe #(.WIDTH(8),  .GROUP(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    ling_adder_pipe #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    ling_adder_pipe #(.WIDTH(32), .GROUP(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    ling_adder_pipe #(.WIDTH(64), .GROUP(4)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    assign if8.in_valid  = in_valid;  assign if8.out_ready  = out_ready;
    assign if16.in_valid = in_valid;  assign if16.out_ready = out_ready;
    assign if32.in_valid = in_valid;  assign if32.out_ready = out_ready;
    assign if64.in_valid = in_valid;  assign if64.out_ready = out_ready;
    assign if8.in_cin  = cin_d;  assign if8.in_sub  = sub_d;
    assign if16.in_cin = cin_d;  assign if16.in_sub = sub_d;
    assign if32.in_cin = cin_d;  assign if32.in_sub = sub_d;
    assign if64.in_cin = cin_d;  assign if64.in_sub = sub_d;
    assign if8.in_a  = a_d[0][7:0];   assign if8.in_b  = b_d[0][7:0];
    assign if16.in_a = a_d[1][15:0];  assign if16.in_b = b_d[1][15:0];
    assign if32.in_a = a_d[2][31:0];  assign if32.in_b = b_d[2][31:0];
    assign if64.in_a = a_d[3];        assign if64.in_b = b_d[3];

    assign ovalid[0] = if8.out_valid;   assign iready[0] = if8.in_ready;
    assign ovalid[1] = if16.out_valid;  assign iready[1] = if16.in_ready;
    assign ovalid[2] = if32.out_valid;  assign iready[2] = if32.in_ready;
    assign ovalid[3] = if64.out_valid;  assign iready[3] = if64.in_ready;
    assign ocout[0] = if8.out_cout;   assign oovf[0] = if8.out_ovf;
    assign ocout[1] = if16.out_cout;  assign oovf[1] = if16.out_ovf;
    assign ocout[2] = if32.out_cout;  assign oovf[2] = if32.out_ovf;
    assign ocout[3] = if64.out_cout;  assign oovf[3] = if64.out_ovf;
    assign osum[0] = {56'd0, if8.out_sum};
    assign osum[1] = {48'd0, if16.out_sum};
    assign osum[2] = {32'd0, if32.out_sum};
    assign osum[3] = if64.out_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "timeout");
    end

    function automatic int widk(input int k);
        return 8 << k;
    endfunction

    function automatic logic [63:0] maskw(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: {ovf, cout, sum} from plain modular arithmetic.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] mk, am, bm, s;
        logic [64:0] full;
        logic        co, ov, sa, sb, ss;
        mk = maskw(w);
        am = a & mk;
        bm = b & mk;
        if (sub) begin
            s  = (am - bm) & mk;
            co = (am >= bm);
        end else begin
            full = {1'b0, am} + {1'b0, bm} + 65'(cin);
            s    = full[63:0] & mk;
            co   = full[w];
        end
        sa = am[w-1];
        sb = bm[w-1];
        ss = s[w-1];
        ov = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return {ov, co, s};
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s w=%0d got=%0h exp=%0h", tag, widk(k), got, exp);
        end
    endtask

    // One clock: check outputs/ready against the models, advance models, step to next negedge.
    task automatic tick();
        logic        ev, er;
        logic [65:0] m;
        #1;
        ev = (q.size() > 0) && (stg[0] == 3);
        er = (q.size() < 3) || out_ready;
        for (int k = 0; k < 4; k++) begin
            chk("out_valid", k, 64'(ovalid[k]), 64'(ev));
            chk("in_ready", k, 64'(iready[k]), 64'(er));
            if (ev) begin
                m = model(widk(k), q[0].a[k], q[0].b[k], q[0].cin, q[0].sub);
                chk("sum", k, osum[k], m[63:0]);
                chk("cout", k, 64'(ocout[k]), 64'(m[64]));
                chk("ovf", k, 64'(oovf[k]), 64'(m[65]));
            end
        end
        if (ev && out_ready) begin
            void'(q.pop_front());
            void'(stg.pop_front());
            emitted++;
        end
        for (int i = 0; i < stg.size(); i++) begin
            if (stg[i] < 3 && (i == 0 || stg[i-1] != stg[i] + 1)) stg[i] = stg[i] + 1;
        end
        last_acc = in_valid && er;
        if (last_acc) begin
            q.push_back('{a: a_d, b: b_d, cin: cin_d, sub: sub_d});
            stg.push_back(1);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_all(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        for (int k = 0; k < 4; k++) begin
            a_d[k] = a;
            b_d[k] = b;
        end
        cin_d = cin;
        sub_d = sub;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        set_all(a, b, cin, sub);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [63:0] bp_a [5];
    logic [63:0] bp_b [5];
    logic        bp_s [5];
    logic [63:0] ra, rb, mk;
    logic [65:0] em;
    int          idx, base, w;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_all(64'd0, 64'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_out_valid", k, 64'(ovalid[k]), 64'd0);
            chk("rst_out_sum", k, osum[k], 64'd0);
            chk("rst_out_cout", k, 64'(ocout[k]), 64'd0);
            chk("rst_out_ovf", k, 64'(oovf[k]), 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // Single beat: latency exactly 3, 0xFFFF + 1 wraps.
        send(64'hFFFF, 64'h1, 1'b0, 1'b0);
        chk("lat_c1_valid", 1, 64'(ovalid[1]), 64'd0);
        tick();
        chk("lat_c2_valid", 1, 64'(ovalid[1]), 64'd0);
        tick();
        chk("lat_c3_valid", 1, 64'(ovalid[1]), 64'd1);
        chk("wrap_sum", 1, osum[1], 64'h0000);
        chk("wrap_cout", 1, 64'(ocout[1]), 64'd1);
        chk("wrap_ovf", 1, 64'(oovf[1]), 64'd0);
        tick();

        // Signed overflow on add, then subtract with cin ignored.
        set_all(64'h7FFF, 64'h1, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        set_all(64'h3, 64'h5, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ovf_sum", 1, osum[1], 64'h8001);
        chk("ovf_cout", 1, 64'(ocout[1]), 64'd0);
        chk("ovf_ovf", 1, 64'(oovf[1]), 64'd1);
        tick();
        chk("sub_sum", 1, osum[1], 64'hFFFE);
        chk("sub_cout", 1, 64'(ocout[1]), 64'd0);
        chk("sub_ovf", 1, 64'(oovf[1]), 64'd0);
        repeat (2) tick();

        // 100 back-to-back random beats.
        base = emitted;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            set_all(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("stream_count", 1, 64'(emitted - base), 64'd100);
        chk("stream_empty", 1, 64'(q.size()), 64'd0);

        // Carry-chain corners at each width.
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 4; k++) begin
                w  = widk(k);
                mk = maskw(w);
                case (c)
                    0: begin a_d[k] = mk;                          b_d[k] = 64'd1; end
                    1: begin a_d[k] = 64'd1 << (w - 1);            b_d[k] = 64'd1; end
                    2: begin a_d[k] = 64'hAAAA_AAAA_AAAA_AAAA & mk; b_d[k] = 64'h5555_5555_5555_5555 & mk; end
                    3: begin a_d[k] = mk;                          b_d[k] = mk; end
                    default: begin a_d[k] = 64'd0;                 b_d[k] = 64'd1; end
                endcase
            end
            cin_d = (c == 2 || c == 3);
            sub_d = (c == 1 || c == 4);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();

        // Back-pressure: 5 offered with out_ready low, only 3 fit.
        for (int n = 0; n < 5; n++) begin
            bp_a[n] = {$urandom, $urandom};
            bp_b[n] = {$urandom, $urandom};
            bp_s[n] = 1'($urandom_range(0, 1));
        end
        base = emitted;
        idx = 0;
        out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            set_all(bp_a[idx], bp_b[idx], 1'b1, bp_s[idx]);
            in_valid = 1'b1;
            tick();
            if (last_acc) idx++;
        end
        chk("bp_accepted", 1, 64'(idx), 64'd3);
        #1;
        chk("bp_full_ready", 1, 64'(iready[1]), 64'd0);
        repeat (2) tick();
        em = model(16, bp_a[0], bp_b[0], 1'b1, bp_s[0]);
        chk("bp_hold_valid", 1, 64'(ovalid[1]), 64'd1);
        chk("bp_hold_sum", 1, osum[1], em[63:0]);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 1, 64'(iready[1]), 64'd1);
        for (int t = 0; t < 20 && idx < 5; t++) begin
            set_all(bp_a[idx], bp_b[idx], 1'b1, bp_s[idx]);
            in_valid = 1'b1;
            tick();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_count", 1, 64'(emitted - base), 64'd5);
        chk("bp_empty", 1, 64'(q.size()), 64'd0);

        // Asynchronous reset with 3 beats in flight.
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            set_all({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("arst_out_valid", k, 64'(ovalid[k]), 64'd0);
            chk("arst_out_sum", k, osum[k], 64'd0);
            chk("arst_out_cout", k, 64'(ocout[k]), 64'd0);
            chk("arst_out_ovf", k, 64'(oovf[k]), 64'd0);
        end
        q.delete();
        stg.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        send(64'h1234, 64'h4321, 1'b0, 1'b0);
        repeat (2) tick();
        chk("post_rst_valid", 1, 64'(ovalid[1]), 64'd1);
        chk("post_rst_sum", 1, osum[1], 64'h5555);
        repeat (4) tick();
        chk("post_rst_empty", 1, 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ling_adder_pipe.md
Name: ling_adder_pipe

Overview:
- Parametrised, 3-stage pipelined Ling adder/subtractor.
- Generalises the fixed 16-bit combinational Ling adders in width, and adds carry-in, carry-out, subtract mode, a signed-overflow flag and a valid/ready stream interface with back-pressure.
- Sits between operand-issue logic and result consumers in the datapath; intended as the drop-in registered adder for widths 16..64.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4, range 8..64.
- GROUP, 4, Ling group size for the stage-2 block recursion; must divide WIDTH; only 4 is required to be supported.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, block can accept a beat this cycle.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- in_cin, input, 1, carry-in; ignored when in_sub=1.
- in_sub, input, 1, 0: A+B+cin; 1: A-B (A+~B+1).
- out_valid, output, 1, result beat valid.
- out_ready, input, 1, consumer accepts result.
- out_sum, output, WIDTH, result modulo 2^WIDTH.
- out_cout, output, 1, carry out of MSB; in subtract mode 1 = no borrow (A>=B unsigned).
- out_ovf, output, 1, two's-complement signed overflow.

Behaviour:
- Reset: rst_n low asynchronously clears all stage valid bits. out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=1 one cycle after release. Data registers are also cleared to 0.
- Reset mid-operation: all in-flight beats are discarded. No result for them is ever presented.
- Datapath: each stage holds a valid bit plus its payload.
  - S1 registers g=a&b', p=a|b', x=a^b', where b'=b^{WIDTH{sub}} and c0=sub?1:cin. It also registers the level-1 pseudo-carry R1 and group propagate Q1 per GROUP bits, using the Ling form H_i = g_i | g_{i-1} | p_{i-1}g_{i-2} | ... with c0 folded in as g_{-1}.
  - S2 registers the full prefix H per bit via group recursion R2 = R1 | Q1·R1(prior group), log2(WIDTH/GROUP) levels.
  - S3 registers the outputs:
    - sum_i = x_i ^ (p_{i-1} & H_{i-1}), with bit 0 using c0.
    - cout = p_{W-1} & H_{W-1}.
    - ovf = c_{W} ^ c_{W-1}.
- Carries are generated only through the Ling H/Q recursion. No behavioural '+' in the synthesised datapath.
- Latency: exactly 3 cycles from an accepted input (in_valid&in_ready) to out_valid, when there is no back-pressure.
- Throughput: 1 beat per cycle when out_ready=1.
- Handshake:
  - A stage loads when its upstream is valid and it is either empty or being drained in the same cycle.
  - in_ready = ~v1 | load2.
  - Payload is held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
  - in_ready may depend combinationally on out_ready. No combinational path exists from in_* to out_*.
- Simultaneous accept and emit on the same cycle: both occur, and occupancy stays constant.
- Full: with 3 beats held and out_ready=0, in_ready=0. It goes to 1 in the same cycle out_ready rises.
- Empty: out_valid=0. Output payload holds its last value and is don't-care.
- Wrap-around: sum is modulo 2^WIDTH, and out_cout reports the dropped bit.
- Ordering: results emerge strictly in acceptance order. No beat is dropped or duplicated.

Test Plan:
- WIDTH=16, single beat a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 3 cycles later out_sum=0x0000, cout=1, ovf=0.
- Addition with overflow: a=0x7FFF, b=0x0001, cin=1 -> sum=0x8001, cout=0, ovf=1. Subtraction: a=0x0003, b=0x0005, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0, with cin ignored.
- Streaming: 100 back-to-back random beats with out_ready=1 -> one result per cycle, in order, each matching a scoreboard model of a+b+cin / a-b (sum, cout, ovf).
- Back-pressure: out_ready=0 while 5 beats are offered -> exactly 3 are accepted and in_ready=0. Output is held stable. Release out_ready -> beats 1..5 appear in order with no loss.
- Reset mid-stream: assert rst_n=0 asynchronously (off clock edge) with 3 beats in flight -> outputs are immediately 0 and out_valid=0. After release, a new beat a=0x1234, b=0x4321 -> sum=0x5555 with no stale results.
- Repeat the random streaming test at WIDTH=8, 32 and 64, including carry-chain corners: all-ones + 1, 0x80..0 - 1, and alternating 0xAA.. + 0x55.. with cin=1 -> exact match with the model.
